cla_multicycle_adder_ctrl: RTL



---
 rtl/cla_multicycle_adder_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cla_multicycle_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead
// slice over NDIG cycles, LSB digit first, with a registered inter-digit carry.

module cla4_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is a flat sum of products of the slice inputs, so no carry
    // has to pass through the lower bits of the slice.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);
    assign cout_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cin_i);
    assign sum_o = p ^ c;
endmodule

module cla_multicycle_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Abort,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);
    localparam int NDIG = WIDTH / 4;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("cla_multicycle_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [3:0]       slice_sum;
    logic             slice_cout;

    cla4_slice u_slice (
        .a_i   (a_q[{idx_q, 2'b00} +: 4]),
        .b_i   (b_q[{idx_q, 2'b00} +: 4]),
        .cin_i (carry_q),
        .sum_o (slice_sum),
        .cout_o(slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{Sub}};
                    carry_d = Sub | Cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (Abort) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    work_d[{idx_q, 2'b00} +: 4] = slice_sum;
                    carry_d = slice_cout;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            S_DONE: begin
                // b_q already holds the inverted operand for subtraction.
                sum_d   = work_q;
                cout_d  = carry_q;
                ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_q[WIDTH-1] != a_q[WIDTH-1]);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign Ready    = (state_q == S_IDLE);
    assign Busy     = (state_q == S_RUN);
    assign Done     = done_q;
    assign Sum      = sum_q;
    assign Cout     = cout_q;
    assign Overflow = ovf_q;
endmodule
